// File: rtl/round_robin_arbiter.sv
// N-way round-robin arbiter. Combinational grant from the current requests;
// only the rotating priority pointer is registered.
module round_robin_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               allow_i,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic               gnt_found_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

    logic [PTR_W-1:0]   ptr_q;
    logic [PTR_W-1:0]   ptr_d;
    logic [NUM_REQ-1:0] thermoMask;
    logic [NUM_REQ-1:0] maskedReq;
    logic [PTR_W-1:0]   maskedIdx;
    logic [PTR_W-1:0]   rawIdx;
    logic [PTR_W-1:0]   gntIdx;
    logic               maskedAny;
    logic               rawAny;
    logic               grantValid;

    // Bits at or above the pointer keep their request; the rest wait for the wrap.
    always_comb begin
        thermoMask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            thermoMask[i] = (PTR_W'(i) >= ptr_q);
        end
        maskedReq = req_i & thermoMask;
    end

    always_comb begin
        maskedIdx = '0;
        rawIdx    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (maskedReq[i]) begin
                maskedIdx = PTR_W'(i);
            end
            if (req_i[i]) begin
                rawIdx = PTR_W'(i);
            end
        end
        maskedAny = |maskedReq;
        rawAny    = |req_i;
        gntIdx    = maskedAny ? maskedIdx : rawIdx;
    end

    // Reset and allow gate the grant without touching the encoder.
    always_comb begin
        grantValid  = !rst_i && allow_i && rawAny;
        gnt_o       = '0;
        gnt_found_o = grantValid;
        ptr_d       = ptr_q;
        if (grantValid) begin
            gnt_o[gntIdx] = 1'b1;
            ptr_d         = (gntIdx == LAST_IDX) ? '0 : gntIdx + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Self-checking bench for round_robin_arbiter: directed vector table followed
// by a randomized soak against a cyclic-scan reference model.
module tb_round_robin_arbiter;

    localparam int N = 4;
    localparam int SOAK_CYCLES = 4000;

    logic         clk;
    logic         rst;
    logic         allow;
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic         gntFound;

    int testsRun;
    int testsFailed;

    round_robin_arbiter #(.NUM_REQ(N)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .allow_i    (allow),
        .req_i      (req),
        .gnt_o      (gnt),
        .gnt_found_o(gntFound)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic         allow;
        logic [N-1:0] req;
        logic [N-1:0] expGnt;
        logic         expFound;
        string        name;
    } vector_t;

    vector_t vecs[$];

    // Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
    task automatic applyStimulus(input logic r, input logic a, input logic [N-1:0] q);
        @(posedge clk);
        #1;
        rst   = r;
        allow = a;
        req   = q;
    endtask

    task automatic checkOutput(input string name, input logic [N-1:0] expGnt, input logic expFound);
        @(negedge clk);
        testsRun++;
        if (gnt !== expGnt || gntFound !== expFound) begin
            testsFailed++;
            $display("[TB] FAIL %s: gnt=%b found=%b, expected gnt=%b found=%b",
                     name, gnt, gntFound, expGnt, expFound);
        end
    endtask

    task automatic checkCond(input string name, input logic ok, input int actual, input int required);
        testsRun++;
        if (ok !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, actual, required);
        end
    endtask

    task automatic addVec(input logic r, input logic a, input logic [N-1:0] q,
                          input logic [N-1:0] eg, input logic ef, input string nm);
        vector_t v;
        v.rst = r; v.allow = a; v.req = q; v.expGnt = eg; v.expFound = ef; v.name = nm;
        vecs.push_back(v);
    endtask

    // Reference model: scan cyclically from the pointer for the first request.
    int modelPtr;

    function automatic int modelPick(input int ptr, input logic [N-1:0] q);
        for (int k = 0; k < N; k++) begin
            if (q[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    initial begin
        logic [N-1:0] stickyReq;
        logic [N-1:0] expGnt;
        int           pick;
        int           waitCnt[N];
        int           grantCnt[N];
        int           worstWait;

        testsRun    = 0;
        testsFailed = 0;
        rst   = 1'b1;
        allow = 1'b0;
        req   = '0;

        addVec(1, 1, 4'b1111, 4'b0000, 0, "reset_gates_grant");
        addVec(0, 1, 4'b1111, 4'b0001, 1, "rotate0");
        addVec(0, 1, 4'b1111, 4'b0010, 1, "rotate1");
        addVec(0, 1, 4'b1111, 4'b0100, 1, "rotate2");
        addVec(0, 1, 4'b1111, 4'b1000, 1, "rotate3");
        addVec(0, 1, 4'b1111, 4'b0001, 1, "rotate_wrap");
        addVec(0, 1, 4'b0000, 4'b0000, 0, "idle_no_req");
        addVec(0, 1, 4'b1111, 4'b0010, 1, "idle_ptr_held");
        addVec(0, 0, 4'b1111, 4'b0000, 0, "disabled0");
        addVec(0, 0, 4'b1111, 4'b0000, 0, "disabled1");
        addVec(0, 0, 4'b1111, 4'b0000, 0, "disabled2");
        addVec(0, 1, 4'b1111, 4'b0100, 1, "reenable_resume");
        addVec(0, 1, 4'b0011, 4'b0001, 1, "wrap_low0");
        addVec(0, 1, 4'b0011, 4'b0010, 1, "wrap_low1");
        addVec(0, 1, 4'b1000, 4'b1000, 1, "single_top");
        addVec(0, 1, 4'b0110, 4'b0010, 1, "after_top_wrap");
        addVec(0, 1, 4'b0101, 4'b0100, 1, "skip_below_ptr");
        addVec(0, 1, 4'b0001, 4'b0001, 1, "only_below_ptr");
        addVec(0, 1, 4'b1111, 4'b0010, 1, "pre_reset");
        addVec(1, 1, 4'b1111, 4'b0000, 0, "midstream_reset");
        addVec(0, 1, 4'b1111, 4'b0001, 1, "post_reset_first");
        addVec(1, 0, 4'b0000, 4'b0000, 0, "reset_idle");

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].allow, vecs[i].req);
            checkOutput(vecs[i].name, vecs[i].expGnt, vecs[i].expFound);
        end

        // Randomized soak from a fresh reset.
        applyStimulus(1, 1, '1);
        checkOutput("soak_reset", '0, 0);
        modelPtr  = 0;
        stickyReq = '0;
        worstWait = 0;
        for (int i = 0; i < N; i++) begin
            waitCnt[i]  = 0;
            grantCnt[i] = 0;
        end

        for (int c = 0; c < SOAK_CYCLES; c++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 3) == 0) stickyReq[b] = ~stickyReq[b];
            end
            applyStimulus(0, ($urandom_range(0, 99) >= 2), stickyReq);
            expGnt = '0;
            pick   = allow ? modelPick(modelPtr, req) : -1;
            if (pick >= 0) expGnt[pick] = 1'b1;
            checkOutput("soak_grant", expGnt, (pick >= 0));
            checkCond("soak_found_eq_or", (gntFound === (|gnt)), int'(gntFound), int'(|gnt));
            checkCond("soak_subset", ((gnt & ~req) == '0), int'(gnt), int'(req));
            checkCond("soak_onehot0", $onehot0(gnt), $countones(gnt), 1);
            if (pick >= 0) modelPtr = (pick + 1) % N;

            // Fairness is observed on the DUT's own grants.
            if (allow) begin
                for (int b = 0; b < N; b++) begin
                    if (gnt[b]) begin
                        grantCnt[b]++;
                        waitCnt[b] = 0;
                    end else if (req[b]) begin
                        waitCnt[b]++;
                        if (waitCnt[b] > worstWait) worstWait = waitCnt[b];
                    end else begin
                        waitCnt[b] = 0;
                    end
                end
            end
        end

        checkCond("fairness_bound", (worstWait < N), worstWait, N - 1);
        for (int b = 0; b < N; b++) begin
            checkCond($sformatf("grant_share%0d", b), (grantCnt[b] >= SOAK_CYCLES / 16),
                      grantCnt[b], SOAK_CYCLES / 16);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
